tanh_deriv_bp: RTL and testbench
================================

TANH_DERIV_BP -- requirements
Module: tanh_deriv_bp

Interface
REQ-001 SHALL have parameter WIDTH, default 24; data word width, signed two's complement.
REQ-002 SHALL have parameter FRAC, default 16; fractional bits, so 1.0 = 24'h010000.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  input operands valid.
REQ-006 SHALL have port i_ready  output  1  block can accept operands.
REQ-007 SHALL have port i_y  input  WIDTH  stored forward tanh output y.
REQ-008 SHALL have port i_delta  input  WIDTH  upstream gradient delta.
REQ-009 SHALL have port i_last  input  1  last element of the gradient vector.
REQ-010 SHALL have port o_valid  output  1  result valid.
REQ-011 SHALL have port o_ready  input  1  downstream accepts result.
REQ-012 SHALL have port o_grad  output  WIDTH  delta*(1 - y*y).
REQ-013 SHALL have port o_last  output  1  i_last captured with the operands.

Function
REQ-014 SHALL implement FSM states IDLE, SQ, MUL, DONE; i_ready = 1 only in IDLE.
REQ-015 IDLE: on i_valid=1, SHALL register i_y, i_delta, i_last and go to SQ; otherwise stay in IDLE.
REQ-016 SQ: SHALL register p = y*y, computed as the full 2*WIDTH product, bits [FRAC+WIDTH-1:FRAC], truncated; then go to MUL.
REQ-017 SQ: if |y| >= 1.0 (24'h010000), SHALL force d = 0 in place of (1.0 - p); this also covers overflow of y*y.
REQ-018 MUL: SHALL register o_grad = delta*d, using the same product slicing; go to DONE.
REQ-019 Any product outside the signed WIDTH range SHALL saturate to 24'h7FFFFF / 24'h800000.
REQ-020 DONE: o_valid SHALL be 1; o_grad and o_last SHALL be held stable while o_ready = 0.
REQ-021 DONE with o_ready=1: SHALL go to IDLE; this gives one result per 4 cycles at most, with no overlap.
REQ-022 Latency: o_valid SHALL rise 3 edges after the accepting edge, counting the accepting edge as 0 (IDLE→SQ at edge 0, SQ→MUL at edge 1, MUL→DONE at edge 2, o_valid high after edge 2).
REQ-023 Inputs presented while i_ready=0 SHALL be ignored and SHALL NOT corrupt the held operands.
REQ-024 A single multiplier instance SHALL be time-shared between SQ and MUL.

Reset
REQ-025 On rst=1 at a clock edge, the state SHALL become IDLE and o_valid, o_grad, o_last and internal operand registers SHALL become 0.
REQ-026 rst SHALL take priority over every transition, including mid-operation in SQ, MUL or DONE; the in-flight result SHALL be discarded.
REQ-027 i_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 Shared package SHALL hold WIDTH, FRAC, ONE_FX (24'h010000), SAT_MAX and SAT_MIN, the state encoding, and constants reused by the tanh forward block.
REQ-029 One sub-module mult_fx (signed WIDTH×WIDTH multiply, slicing at FRAC, saturation) SHALL be instantiated once.
REQ-030 The FSM, operand registers and output registers SHALL reside in tanh_deriv_bp.

Verification
REQ-031 y=24'h008000, delta=24'h010000, o_ready=1 → o_grad=24'h00C000, o_valid high 3 edges after accept.
REQ-032 y=24'hFF8000, delta=24'hFF0000 → o_grad=24'hFF4000; y=0, delta=24'h020000 → 24'h020000.
REQ-033 y=24'h010000 and y=24'h050000, any delta → o_grad=0.
REQ-034 o_ready held low 5 cycles in DONE → o_grad and o_last stable, i_ready=0, new i_valid ignored; the release cycle gives exactly one transfer.
REQ-035 rst asserted for 1 cycle while in MUL → next cycle o_valid=0, i_ready=1; the next operand pair completes correctly.
REQ-036 Back-to-back stream of 8 operands with i_last on the 8th → 8 results in order, o_last=1 only on the 8th.

Source files
------------

// File: rtl/tanh_deriv_bp_pkg.sv
// tanh_deriv_bp_pkg: shared fixed-point constants and FSM encoding for the tanh forward/backward blocks
package tanh_deriv_bp_pkg;
  localparam int WIDTH = 24;
  localparam int FRAC = 16;
  localparam logic [23:0] ONE_FX = 24'h010000;
  localparam logic [23:0] SAT_MAX = 24'h7FFFFF;
  localparam logic [23:0] SAT_MIN = 24'h800000;
  // forward tanh treats |x| beyond this as fully saturated
  localparam logic [23:0] TANH_CLAMP = 24'h030000;
  typedef enum logic [1:0] {IDLE, SQ, MUL, DONE} state_t;
endpackage

// File: rtl/tanh_deriv_bp_mult_fx.sv
// mult_fx: signed fixed-point multiply, sliced at FRAC with saturation to the WIDTH range
module mult_fx #(
  parameter int WIDTH = tanh_deriv_bp_pkg::WIDTH,
  parameter int FRAC = tanh_deriv_bp_pkg::FRAC
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);
  import tanh_deriv_bp_pkg::*;
  logic [2*WIDTH-1:0] full;
  logic [WIDTH-FRAC:0] top;
  logic unused;
  always_comb begin
    full = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    top = full[2*WIDTH-1:FRAC+WIDTH-1];
    p = (&top || ~|top) ? full[FRAC+WIDTH-1:FRAC] : {full[2*WIDTH-1], {(WIDTH-1){~full[2*WIDTH-1]}}};
  end
  assign unused = ^full[FRAC-1:0];
endmodule

// File: rtl/tanh_deriv_bp.sv
// tanh_deriv_bp: backprop through tanh, o_grad = delta*(1 - y*y), one shared multiplier over SQ/MUL
module tanh_deriv_bp #(
  parameter int WIDTH = tanh_deriv_bp_pkg::WIDTH,
  parameter int FRAC = tanh_deriv_bp_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_delta,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_grad,
  output logic             o_last
);
  import tanh_deriv_bp_pkg::*;
  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
  state_t state, nxt;
  logic signed [WIDTH-1:0] y, delta, d;
  logic [WIDTH-1:0] a, b, p;
  logic last;
  assign i_ready = state == IDLE;
  assign o_valid = state == DONE;
  always_comb begin
    nxt = state == IDLE ? (i_valid ? SQ : IDLE) :
          state == SQ   ? MUL :
          state == MUL  ? DONE :
          (o_ready ? IDLE : DONE);
    a = state == MUL ? delta : y;
    b = state == MUL ? d : y;
  end
  mult_fx #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (.a(a), .b(b), .p(p));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y <= '0;
      delta <= '0;
      last <= 1'b0;
      d <= '0;
      o_grad <= '0;
      o_last <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && i_valid) begin
        y <= i_y;
        delta <= i_delta;
        last <= i_last;
      end
      // |y| >= 1 also catches every y whose square would overflow
      if (state == SQ) d <= (y >= ONE || y <= NEG_ONE) ? '0 : ONE - p;
      if (state == MUL) begin
        o_grad <= p;
        o_last <= last;
      end
    end
  end
endmodule

// File: tb/tb_tanh_deriv_bp.sv
// tb_tanh_deriv_bp: randomized and directed checks of tanh_deriv_bp against an arithmetic model
module tb_tanh_deriv_bp;
  logic clk = 0, rst = 1, i_valid = 0, i_last = 0, o_ready = 0;
  logic [23:0] i_y = 0, i_delta = 0;
  logic i_ready, o_valid, o_last;
  logic [23:0] o_grad;
  int n_cmp = 0, n_bad = 0, ph = 0, xfer = 0, lastcnt = 0;
  bit armed = 0;
  logic [23:0] e_grad = 0;
  logic e_last = 0;

  tanh_deriv_bp dut (.clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_y(i_y),
    .i_delta(i_delta), .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready), .o_grad(o_grad),
    .o_last(o_last));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_grad(input logic signed [23:0] y, input logic signed [23:0] dl);
    longint yy, dd, dv, g;
    logic [23:0] r;
    yy = y;
    dd = dl;
    dv = (yy >= 65536 || yy <= -65536) ? 0 : 65536 - ((yy * yy) >>> 16);
    g = (dd * dv) >>> 16;
    g = g > 64'sd8388607 ? 64'sd8388607 : g < -64'sd8388608 ? -64'sd8388608 : g;
    r = g[23:0];
    return r;
  endfunction

  function automatic logic [23:0] rnd_y();
    int s;
    logic [23:0] edges [4];
    s = $urandom_range(0, 3);
    edges = '{24'h010000, 24'hFF0000, 24'h00FFFF, 24'hFF0001};
    return s == 0 ? 24'($urandom_range(0, 131070)) - 24'd65535 :
           s == 1 ? 24'($urandom) :
           s == 2 ? edges[$urandom_range(0, 3)] :
           24'($urandom_range(0, 255)) + 24'h00FF80;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] y, input logic [23:0] dl, input logic l);
    bit acc, ok;
    ok = 0;
    i_valid = 1;
    i_y = y;
    i_delta = dl;
    i_last = l;
    for (int k = 0; k < 50; k++) begin
      acc = i_ready;
      tick();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    i_valid = 0;
    chk("accept", ok, 1);
  endtask

  // cycle-level model: accepted pair appears 3 edges later and is held until taken
  always @(negedge clk) begin
    if (armed) begin
      chk("i_ready", i_ready, ph == 0);
      chk("o_valid", o_valid, ph == 3);
      if (ph == 3) begin
        chk("o_grad", o_grad, e_grad);
        chk("o_last", o_last, e_last);
      end
      if (rst) ph = 0;
      else if (ph == 0) begin
        if (i_valid) begin
          e_grad = ref_grad(i_y, i_delta);
          e_last = i_last;
          ph = 1;
        end
      end else if (ph < 3) ph++;
      else if (o_ready) begin
        ph = 0;
        xfer++;
        lastcnt += int'(e_last);
      end
    end
  end

  initial begin
    logic [23:0] ys [7], ds [7], gs [7];
    int x0, l0;
    ys = '{24'h008000, 24'hFF8000, 24'h000000, 24'h010000, 24'h050000, 24'hFF0000, 24'h800000};
    ds = '{24'h010000, 24'hFF0000, 24'h020000, 24'h123456, 24'h7ABCDE, 24'h400000, 24'h012345};
    gs = '{24'h00C000, 24'hFF4000, 24'h020000, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
    chk("model_a", ref_grad(24'h008000, 24'h010000), 24'h00C000);
    chk("model_b", ref_grad(24'hFF8000, 24'hFF0000), 24'hFF4000);
    chk("model_c", ref_grad(24'h004000, 24'h030000), 24'h02D000);
    chk("model_d", ref_grad(24'h002000, 24'hFFF000), 24'hFFF040);
    tick();
    tick();
    armed = 1;
    tick();
    rst = 0;
    chk("rst_grad", o_grad, 0);
    chk("rst_last", o_last, 0);
    chk("rst_ready", i_ready, 1);
    o_ready = 1;
    for (int i = 0; i < 7; i++) begin
      send(ys[i], ds[i], 0);
      tick();
      chk("lat_e1", o_valid, 0);
      tick();
      chk("lat_e2", o_valid, 1);
      chk("dir_grad", o_grad, gs[i]);
      tick();
    end
    o_ready = 0;
    send(24'h004000, 24'h030000, 1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      i_valid = 1;
      i_y = rnd_y();
      i_delta = 24'($urandom);
      i_last = 0;
      tick();
      chk("hold_grad", o_grad, 24'h02D000);
      chk("hold_last", o_last, 1);
      chk("hold_ready", i_ready, 0);
    end
    i_valid = 0;
    x0 = xfer;
    o_ready = 1;
    tick();
    o_ready = 0;
    tick();
    chk("release_once", xfer - x0, 1);
    chk("release_idle", o_valid, 0);
    o_ready = 1;
    send(24'h00C000, 24'h010000, 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mul_rst_valid", o_valid, 0);
    chk("mul_rst_ready", i_ready, 1);
    send(24'h002000, 24'hFFF000, 0);
    tick();
    tick();
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_grad", o_grad, 24'hFFF040);
    tick();
    x0 = xfer;
    l0 = lastcnt;
    for (int i = 0; i < 8; i++) send(rnd_y(), 24'($urandom), i == 7);
    for (int k = 0; k < 100 && xfer - x0 < 8; k++) tick();
    chk("stream_count", xfer - x0, 8);
    chk("stream_lasts", lastcnt - l0, 1);
    for (int i = 0; i < 400; i++) begin
      i_valid = 1'($urandom);
      i_y = rnd_y();
      i_delta = 24'($urandom);
      i_last = 1'($urandom);
      o_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 49) == 0;
      tick();
    end
    rst = 0;
    i_valid = 0;
    o_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("drain_idle", i_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
